// File: rtl/pipeline_run_monitor_pkg.sv
// Shared types and constants for the pipeline run monitor.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package pipeline_run_monitor_pkg;

  // Run-control states; the encoding is fixed so it can be read from a debug tap.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    DRAIN   = 3'd2,
    DONE    = 3'd3,
    TIMEOUT = 3'd4
  } run_state_t;

  // Conventional meaning of the generic event channels.
  localparam int EVT_STALL   = 0;
  localparam int EVT_FLUSH   = 1;
  localparam int EVT_LOADUSE = 2;
  localparam int EVT_BRANCH  = 3;

  // States in which the program is considered live and counters advance.
  function automatic logic is_active(input run_state_t s);
    return (s == RUN) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/pipeline_run_monitor_if.sv
// Bundle of control strobes and counter readout between the CPU side and the monitor.
// Latency: n/a (wires only).
// Backpressure: none; all inputs are sampled every cycle, outputs are always valid.
interface pipeline_run_monitor_if #(
  parameter int CNT_W   = 32,
  parameter int NUM_EVT = 4
) ();

  logic                     start;
  logic                     clear;
  logic                     end_program;
  logic                     retire_valid;
  logic [NUM_EVT-1:0]       evt;

  logic                     running;
  logic                     done;
  logic                     timed_out;
  logic [CNT_W-1:0]         cycle_count;
  logic [CNT_W-1:0]         retire_count;
  logic [NUM_EVT*CNT_W-1:0] evt_count;
  logic                     overflow;

  // Driver of the run-control strobes (CPU / bench side).
  modport master (
    output start, clear, end_program, retire_valid, evt,
    input  running, done, timed_out, cycle_count, retire_count, evt_count, overflow
  );

  // The monitor itself.
  modport slave (
    input  start, clear, end_program, retire_valid, evt,
    output running, done, timed_out, cycle_count, retire_count, evt_count, overflow
  );

endinterface

// File: rtl/pipeline_run_monitor_sat.sv
// Saturating enable-increment counter with synchronous clear and a wrap-attempt flag.
// Latency: count updates on the edge after inc; wrap is combinational from inc and count.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  logic at_max;

  assign at_max = &count;
  // An increment requested while already at all-ones is the wrap the caller must see.
  assign wrap   = inc & at_max;

  // Count register: clear beats increment, and the value sticks at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_run_monitor.sv
// Run-control FSM and performance counters for the pipelined CPU (start/drain/done/watchdog).
// Latency: status decoded from registered state; done rises DRAIN_CYCLES+1 edges after end_program.
// Backpressure: none; DONE and TIMEOUT freeze all counters until clear or reset.
module pipeline_run_monitor
  import pipeline_run_monitor_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter int NUM_EVT        = 4,
  parameter int DRAIN_CYCLES   = 5,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  pipeline_run_monitor_if.slave   bus
);

  // Drain counter only needs to hold DRAIN_CYCLES-1.
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  // Watchdog fires on the edge where cycle_count steps onto TIMEOUT_CYCLES.
  localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [63:0] WD_LAST = 64'(TIMEOUT_CYCLES) - 64'd1;

  localparam int NCNT = 2 + NUM_EVT;

  run_state_t        state;
  run_state_t        state_next;
  logic [DW-1:0]     drain_cnt;
  logic [DW-1:0]     drain_next;
  logic              active;
  logic              wd_hit;
  logic [NCNT-1:0]   cnt_inc;
  logic [NCNT-1:0]   cnt_wrap;
  logic [CNT_W-1:0]  cnt_val [NCNT];
  logic              overflow_q;

  assign active = is_active(state);
  assign wd_hit = WD_EN && active && (64'(cnt_val[0]) == WD_LAST);

  // Counter enables: index 0 cycles, 1 retirements, 2.. event channels.
  assign cnt_inc[0] = active;
  assign cnt_inc[1] = active & bus.retire_valid;
  for (genvar i = 0; i < NUM_EVT; i++) begin : g_evt_inc
    assign cnt_inc[2+i] = active & bus.evt[i];
  end

  for (genvar c = 0; c < NCNT; c++) begin : g_cnt
    sat_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (bus.clear),
      .inc   (cnt_inc[c]),
      .count (cnt_val[c]),
      .wrap  (cnt_wrap[c])
    );
  end

  // State and drain-counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_next;
    end
  end

  // Next state: clear > watchdog > end_program / drain expiry > start.
  always_comb begin
    state_next = state;
    drain_next = drain_cnt;
    if (bus.clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) state_next = RUN;
        end
        RUN: begin
          if (wd_hit) begin
            state_next = TIMEOUT;
          end else if (bus.end_program) begin
            if (DRAIN_CYCLES == 0) begin
              state_next = DONE;
            end else begin
              state_next = DRAIN;
              drain_next = DRAIN_LOAD;
            end
          end
        end
        DRAIN: begin
          // end_program is deliberately not looked at here; the drain always completes.
          if (wd_hit) begin
            state_next = TIMEOUT;
          end else if (drain_cnt == '0) begin
            state_next = DONE;
          end else begin
            drain_next = drain_cnt - DW'(1);
          end
        end
        default: begin
          // DONE and TIMEOUT hold until clear or reset.
          state_next = state;
        end
      endcase
    end
  end

  // Sticky overflow: any counter that tried to step past all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if (bus.clear) begin
      overflow_q <= 1'b0;
    end else if (|cnt_wrap) begin
      overflow_q <= 1'b1;
    end
  end

  assign bus.running      = active;
  assign bus.done         = (state == DONE);
  assign bus.timed_out    = (state == TIMEOUT);
  assign bus.cycle_count  = cnt_val[0];
  assign bus.retire_count = cnt_val[1];
  assign bus.overflow     = overflow_q;
  for (genvar i = 0; i < NUM_EVT; i++) begin : g_evt_out
    assign bus.evt_count[i*CNT_W +: CNT_W] = cnt_val[2+i];
  end

endmodule

// File: tb/tb_pipeline_run_monitor.sv
// Directed bench for pipeline_run_monitor across four parameter sets.
// Latency: n/a.
// Backpressure: n/a.
module tb_pipeline_run_monitor;
  import pipeline_run_monitor_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // a: defaults; b: no drain; c: short watchdog; d: 4-bit counters
  pipeline_run_monitor_if #(.CNT_W(32), .NUM_EVT(4)) bus_a ();
  pipeline_run_monitor_if #(.CNT_W(32), .NUM_EVT(4)) bus_b ();
  pipeline_run_monitor_if #(.CNT_W(32), .NUM_EVT(4)) bus_c ();
  pipeline_run_monitor_if #(.CNT_W(4),  .NUM_EVT(4)) bus_d ();

  pipeline_run_monitor #(.CNT_W(32), .NUM_EVT(4), .DRAIN_CYCLES(5), .TIMEOUT_CYCLES(100000))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  pipeline_run_monitor #(.CNT_W(32), .NUM_EVT(4), .DRAIN_CYCLES(0), .TIMEOUT_CYCLES(100000))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));
  pipeline_run_monitor #(.CNT_W(32), .NUM_EVT(4), .DRAIN_CYCLES(5), .TIMEOUT_CYCLES(20))
    dut_c (.clk(clk), .reset(reset), .bus(bus_c));
  pipeline_run_monitor #(.CNT_W(4),  .NUM_EVT(4), .DRAIN_CYCLES(5), .TIMEOUT_CYCLES(100000))
    dut_d (.clk(clk), .reset(reset), .bus(bus_d));

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic init_inputs();
    bus_a.start = 0; bus_a.clear = 0; bus_a.end_program = 0; bus_a.retire_valid = 0; bus_a.evt = '0;
    bus_b.start = 0; bus_b.clear = 0; bus_b.end_program = 0; bus_b.retire_valid = 0; bus_b.evt = '0;
    bus_c.start = 0; bus_c.clear = 0; bus_c.end_program = 0; bus_c.retire_valid = 0; bus_c.evt = '0;
    bus_d.start = 0; bus_d.clear = 0; bus_d.end_program = 0; bus_d.retire_valid = 0; bus_d.evt = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    checks++;
    if ({bus_a.running, bus_a.done, bus_a.timed_out, bus_a.overflow} !== 4'b0000) begin
      errors++; $display("FAIL reset_status_a: got %b want 0000",
                         {bus_a.running, bus_a.done, bus_a.timed_out, bus_a.overflow});
    end
    checks++;
    if ({bus_a.cycle_count, bus_a.retire_count, bus_a.evt_count} !== '0) begin
      errors++; $display("FAIL reset_counts_a: cycle %0d retire %0d evt %h want all 0",
                         bus_a.cycle_count, bus_a.retire_count, bus_a.evt_count);
    end
    checks++;
    if ({bus_d.running, bus_d.done, bus_d.timed_out, bus_d.overflow, bus_d.cycle_count} !== 8'h00) begin
      errors++; $display("FAIL reset_d: got %b want 0", 
                         {bus_d.running, bus_d.done, bus_d.timed_out, bus_d.overflow, bus_d.cycle_count});
    end
    reset = 1'b1;
    tick();
  endtask

  // Drain of 5 after 10 RUN cycles; done 6 edges after end_program is sampled.
  task automatic test_run_drain();
    bus_a.start = 1; tick();
    bus_a.start = 0; bus_a.retire_valid = 1;
    checks++;
    if (bus_a.running !== 1'b1 || bus_a.cycle_count !== 32'd0) begin
      errors++; $display("FAIL start_edge: running %b cycle %0d want 1 / 0", bus_a.running, bus_a.cycle_count);
    end
    for (int k = 1; k <= 10; k++) begin
      bus_a.evt = '0;
      bus_a.evt[EVT_BRANCH] = (k == 1 || k == 3);
      bus_a.evt[EVT_STALL]  = (k == 5);
      tick();
    end
    bus_a.evt = '0;
    checks++;
    if (bus_a.cycle_count !== 32'd10 || bus_a.evt_count[EVT_BRANCH*32 +: 32] !== 32'd2 ||
        bus_a.evt_count[EVT_STALL*32 +: 32] !== 32'd1) begin
      errors++; $display("FAIL run_counts: cycle %0d branch %0d stall %0d want 10 2 1", bus_a.cycle_count,
                         bus_a.evt_count[EVT_BRANCH*32 +: 32], bus_a.evt_count[EVT_STALL*32 +: 32]);
    end
    bus_a.end_program = 1; tick();
    checks++;
    if ({bus_a.running, bus_a.done} !== 2'b10 || bus_a.cycle_count !== 32'd11) begin
      errors++; $display("FAIL drain_entry: run/done %b cycle %0d want 10 / 11",
                         {bus_a.running, bus_a.done}, bus_a.cycle_count);
    end
    bus_a.end_program = 0;  // dropping it mid-drain must not matter
    repeat (4) tick();
    checks++;
    if ({bus_a.running, bus_a.done} !== 2'b10 || bus_a.cycle_count !== 32'd15) begin
      errors++; $display("FAIL drain_last: run/done %b cycle %0d want 10 / 15",
                         {bus_a.running, bus_a.done}, bus_a.cycle_count);
    end
    tick();
    checks++;
    if ({bus_a.running, bus_a.done, bus_a.timed_out} !== 3'b010 || bus_a.cycle_count !== 32'd16 ||
        bus_a.retire_count !== 32'd16) begin
      errors++; $display("FAIL done_rise: status %b cycle %0d retire %0d want 010 16 16",
                         {bus_a.running, bus_a.done, bus_a.timed_out}, bus_a.cycle_count, bus_a.retire_count);
    end
    bus_a.end_program = 1; bus_a.start = 1; tick();
    bus_a.start = 0; tick();
    checks++;
    if (bus_a.done !== 1'b1 || bus_a.cycle_count !== 32'd16 || bus_a.retire_count !== 32'd16) begin
      errors++; $display("FAIL done_frozen: done %b cycle %0d retire %0d want 1 16 16",
                         bus_a.done, bus_a.cycle_count, bus_a.retire_count);
    end
    bus_a.end_program = 0; bus_a.retire_valid = 0;
  endtask

  // Clear together with start in DONE, then a fresh run.
  task automatic test_clear_start();
    bus_a.clear = 1; bus_a.start = 1; tick();
    bus_a.clear = 0; bus_a.start = 0;
    checks++;
    if ({bus_a.running, bus_a.done, bus_a.timed_out, bus_a.overflow} !== 4'b0000 ||
        bus_a.cycle_count !== 32'd0 || bus_a.retire_count !== 32'd0 || bus_a.evt_count !== '0) begin
      errors++; $display("FAIL clear_start: status %b cycle %0d retire %0d want 0000 0 0",
                         {bus_a.running, bus_a.done, bus_a.timed_out, bus_a.overflow},
                         bus_a.cycle_count, bus_a.retire_count);
    end
    tick();
    checks++;
    if (bus_a.running !== 1'b0) begin
      errors++; $display("FAIL clear_stays_idle: running %b want 0", bus_a.running);
    end
    bus_a.start = 1; tick();
    bus_a.start = 0; tick();
    checks++;
    if (bus_a.running !== 1'b1 || bus_a.cycle_count !== 32'd1) begin
      errors++; $display("FAIL restart: running %b cycle %0d want 1 / 1", bus_a.running, bus_a.cycle_count);
    end
  endtask

  // Asynchronous reset while draining, then end_program left high after release.
  task automatic test_reset_mid_drain();
    bus_a.end_program = 1; tick();
    tick();
    checks++;
    if (bus_a.running !== 1'b1 || bus_a.cycle_count !== 32'd3) begin
      errors++; $display("FAIL pre_reset_drain: running %b cycle %0d want 1 / 3", bus_a.running, bus_a.cycle_count);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({bus_a.running, bus_a.done, bus_a.timed_out, bus_a.overflow} !== 4'b0000 ||
        bus_a.cycle_count !== 32'd0) begin
      errors++; $display("FAIL async_reset: status %b cycle %0d want 0000 / 0",
                         {bus_a.running, bus_a.done, bus_a.timed_out, bus_a.overflow}, bus_a.cycle_count);
    end
    tick();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if ({bus_a.running, bus_a.done, bus_a.timed_out} !== 3'b000 || bus_a.cycle_count !== 32'd0) begin
      errors++; $display("FAIL idle_ignores_end: status %b cycle %0d want 000 / 0",
                         {bus_a.running, bus_a.done, bus_a.timed_out}, bus_a.cycle_count);
    end
    bus_a.end_program = 0;
  endtask

  // DRAIN_CYCLES=0: done on the very edge end_program is sampled.
  task automatic test_no_drain();
    bus_b.start = 1; tick();
    bus_b.start = 0;
    repeat (3) tick();
    checks++;
    if (bus_b.running !== 1'b1 || bus_b.cycle_count !== 32'd3) begin
      errors++; $display("FAIL nodrain_run: running %b cycle %0d want 1 / 3", bus_b.running, bus_b.cycle_count);
    end
    bus_b.end_program = 1; tick();
    checks++;
    if ({bus_b.running, bus_b.done} !== 2'b01 || bus_b.cycle_count !== 32'd4) begin
      errors++; $display("FAIL nodrain_done: run/done %b cycle %0d want 01 / 4",
                         {bus_b.running, bus_b.done}, bus_b.cycle_count);
    end
    bus_b.start = 1; tick();
    bus_b.start = 0; tick();
    checks++;
    if (bus_b.done !== 1'b1 || bus_b.cycle_count !== 32'd4) begin
      errors++; $display("FAIL nodrain_start_ignored: done %b cycle %0d want 1 / 4", bus_b.done, bus_b.cycle_count);
    end
    bus_b.end_program = 0;
  endtask

  // TIMEOUT_CYCLES=20, with end_program arriving on the watchdog edge itself.
  task automatic test_watchdog();
    bus_c.start = 1; tick();
    bus_c.start = 0; bus_c.retire_valid = 1;
    repeat (19) tick();
    checks++;
    if ({bus_c.running, bus_c.timed_out} !== 2'b10 || bus_c.cycle_count !== 32'd19) begin
      errors++; $display("FAIL wd_before: run/to %b cycle %0d want 10 / 19",
                         {bus_c.running, bus_c.timed_out}, bus_c.cycle_count);
    end
    bus_c.end_program = 1; tick();
    checks++;
    if ({bus_c.running, bus_c.done, bus_c.timed_out} !== 3'b001 || bus_c.cycle_count !== 32'd20 ||
        bus_c.retire_count !== 32'd20) begin
      errors++; $display("FAIL wd_fire: status %b cycle %0d retire %0d want 001 20 20",
                         {bus_c.running, bus_c.done, bus_c.timed_out}, bus_c.cycle_count, bus_c.retire_count);
    end
    bus_c.evt = '1;
    repeat (10) tick();
    checks++;
    if ({bus_c.done, bus_c.timed_out} !== 2'b01 || bus_c.cycle_count !== 32'd20 ||
        bus_c.retire_count !== 32'd20 || bus_c.evt_count !== '0) begin
      errors++; $display("FAIL wd_frozen: done/to %b cycle %0d retire %0d evt %h want 01 20 20 0",
                         {bus_c.done, bus_c.timed_out}, bus_c.cycle_count, bus_c.retire_count, bus_c.evt_count);
    end
    bus_c.evt = '0; bus_c.retire_valid = 0; bus_c.end_program = 0;
  endtask

  // CNT_W=4: flush channel held high for 20 cycles saturates at 15.
  task automatic test_saturation();
    bus_d.start = 1; tick();
    bus_d.start = 0;
    for (int k = 1; k <= 20; k++) begin
      bus_d.evt = '0;
      bus_d.evt[EVT_FLUSH]   = 1'b1;
      bus_d.evt[EVT_LOADUSE] = (k <= 3);
      tick();
      if (k == 15) begin
        checks++;
        if (bus_d.evt_count[EVT_FLUSH*4 +: 4] !== 4'd15 || bus_d.overflow !== 1'b0) begin
          errors++; $display("FAIL sat_at_max: evt1 %0d ovf %b want 15 / 0",
                             bus_d.evt_count[EVT_FLUSH*4 +: 4], bus_d.overflow);
        end
      end
      if (k == 16) begin
        checks++;
        if (bus_d.evt_count[EVT_FLUSH*4 +: 4] !== 4'd15 || bus_d.overflow !== 1'b1) begin
          errors++; $display("FAIL sat_wrap: evt1 %0d ovf %b want 15 / 1",
                             bus_d.evt_count[EVT_FLUSH*4 +: 4], bus_d.overflow);
        end
      end
    end
    bus_d.evt = '0;
    checks++;
    if (bus_d.evt_count !== 16'h03F0 || bus_d.cycle_count !== 4'd15) begin
      errors++; $display("FAIL sat_channels: evt %h cycle %0d want 03f0 / 15", bus_d.evt_count, bus_d.cycle_count);
    end
    bus_d.end_program = 1;
    repeat (6) tick();
    checks++;
    if (bus_d.done !== 1'b1 || bus_d.overflow !== 1'b1 || bus_d.evt_count !== 16'h03F0) begin
      errors++; $display("FAIL sat_sticky: done %b ovf %b evt %h want 1 1 03f0",
                         bus_d.done, bus_d.overflow, bus_d.evt_count);
    end
    bus_d.end_program = 0;
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_run_drain();
    test_clear_start();
    test_reset_mid_drain();
    test_no_drain();
    test_watchdog();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_run_monitor.md
Name: pipeline_run_monitor

Overview:
Synthesizable run-control and performance-counter unit for cpu_pipelined. It replaces ad-hoc cycle counting and end_program polling in benches. It tracks program start, cycles, retired instructions and NUM_EVT hazard/event channels, then waits a parametrised pipeline-drain window after end_program before reporting done. A watchdog flags hung programs and freezes all counters for readout.

Parameters:
CNT_W, 32, width of every counter
NUM_EVT, 4, number of generic event channels (stall, flush, load-use, branch-taken by convention)
DRAIN_CYCLES, 5, edges spent in DRAIN after end_program; 0 allowed
TIMEOUT_CYCLES, 100000, watchdog limit on cycle_count; 0 disables the watchdog

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  single-cycle pulse; begins a run from IDLE
clear  in  1  synchronous clear; returns to IDLE and zeroes all counters
end_program  in  1  CPU end-of-program flag, level
retire_valid  in  1  one instruction retired (writeback) this cycle
evt  in  NUM_EVT  per-channel event strobes
running  out  1  state is RUN or DRAIN
done  out  1  state is DONE
timed_out  out  1  state is TIMEOUT
cycle_count  out  CNT_W  cycles counted during RUN and DRAIN
retire_count  out  CNT_W  retired instructions
evt_count  out  NUM_EVT*CNT_W  channel i at bits [i*CNT_W +: CNT_W]
overflow  out  1  sticky; some counter saturated

Behaviour:
- All outputs are registered or decoded from state. While reset=0: state=IDLE, all counters=0, overflow=0, running=done=timed_out=0. Reset asserted mid-run aborts immediately.
- States: IDLE, RUN, DRAIN, DONE, TIMEOUT.
- IDLE: start=1 -> RUN. end_program is ignored in IDLE.
- RUN: end_program=1 -> DRAIN, loading drain counter with DRAIN_CYCLES-1. If DRAIN_CYCLES=0, RUN -> DONE directly.
- DRAIN: decrement each edge; at 0 -> DONE. end_program dropping during DRAIN is ignored.
- DONE and TIMEOUT are terminal. Counters are frozen. Only clear or reset leave these states.
- Counting: at each edge where the pre-edge state is RUN or DRAIN:
  - cycle_count += 1
  - retire_count += retire_valid
  - evt_count[i] += evt[i]
  - This includes the edge that leaves RUN or DRAIN.
  - The start edge itself does not count, so cycle_count=1 one edge after start.
- Saturation: every counter holds at all-ones instead of wrapping. overflow is set on the edge any counter would have wrapped and stays set until clear or reset.
- Watchdog (TIMEOUT_CYCLES!=0): in RUN or DRAIN, if cycle_count==TIMEOUT_CYCLES-1 at an edge, the counters update, so cycle_count==TIMEOUT_CYCLES, and the state goes to TIMEOUT.
- Priority per edge: reset > clear > watchdog > end_program/drain expiry > start.
  - Watchdog beats a simultaneous end_program or final drain edge.
  - clear together with start: clear wins and the state stays IDLE.
- start while not in IDLE is ignored.
- Latency: done rises exactly DRAIN_CYCLES+1 edges after the edge on which end_program is first sampled high in RUN (1 edge if DRAIN_CYCLES=0).

Decomposition:
- Shared package holds:
  - the state enum (IDLE, RUN, DRAIN, DONE, TIMEOUT) with fixed 3-bit encoding 0..4
  - event channel index constants EVT_STALL=0, EVT_FLUSH=1, EVT_LOADUSE=2, EVT_BRANCH=3
- One sub-module, sat_counter: a CNT_W-wide enable-increment counter with synchronous clear and a saturation flag. It is instantiated 2+NUM_EVT times, and the OR of the flags drives overflow.

Test Plan:
1. Reset low, then high; pulse start; hold retire_valid=1 for 10 cycles; raise end_program at cycle 10 (DRAIN_CYCLES=5) -> done rises 6 edges later; cycle_count=16; retire_count=16; running=0.
2. DRAIN_CYCLES=0; start, then end_program after 3 cycles -> done one edge after end_program is sampled; cycle_count=4.
3. TIMEOUT_CYCLES=20, end_program never asserted -> timed_out=1 with cycle_count=20 exactly. Counters stay frozen for 10 more cycles; done stays 0.
4. CNT_W=4, evt[1] held high for 20 running cycles -> evt_count[1] saturates at 15; overflow=1 and sticky; other channels unaffected.
5. Reset driven low mid-DRAIN -> all outputs 0 immediately (asynchronous, before the next clk edge); state is IDLE after release; end_program still high does not advance the state.
6. In DONE, pulse clear together with start -> IDLE, all counters 0, overflow 0. A start pulse next cycle begins a new run with cycle_count restarting from 1.
